// File: rtl/decodificador_cadeia_if.sv
`default_nettype none
// =============================================================================
// Module      : decodificador_cadeia_if
// Description : Token/result bundle between the symbol front end and the
//               path decoder.
// Revision    : 1.0 - initial release
// =============================================================================
interface decodificador_cadeia_if #(
    parameter int PW = 3
) ();
    logic          Controle;
    logic [PW+1:0] Entrada;
    logic [PW:0]   Saida;
    logic [7:0]    Passos;
    logic          Fim;
    logic          Evento;

    modport master (
        output Controle,
        output Entrada,
        input  Saida,
        input  Passos,
        input  Fim,
        input  Evento
    );

    modport slave (
        input  Controle,
        input  Entrada,
        output Saida,
        output Passos,
        output Fim,
        output Evento
    );
endinterface
`default_nettype wire

// File: rtl/decodificador_cadeia.sv
`default_nettype none
// =============================================================================
// Module      : decodificador_cadeia
// Description : Token-driven walker over a chain of N_POS positions ending in
//               ERRO, ACEITO_LO or ACEITO_HI. Optional inactivity timeout is
//               built when DECOD_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
module decodificador_cadeia #(
    parameter int PW         = 3,
    parameter int N_POS      = 5,
    parameter int SPLIT      = 3,
    parameter int MAX_PASSOS = 15,
    parameter int TIMEOUT    = 255
) (
    input  wire logic              clk,
    input  wire logic              Reset,
    decodificador_cadeia_if.slave  bus
);

    localparam logic [1:0]  c_OP_MOVE   = 2'b00;
    localparam logic [1:0]  c_OP_ACC_LO = 2'b01;
    localparam logic [1:0]  c_OP_ACC_HI = 2'b10;
    localparam logic [1:0]  c_OP_ABORT  = 2'b11;

    // State codes double as the Saida encoding: MSB set means terminal.
    localparam logic [PW:0] c_IDLE      = '0;
    localparam logic [PW:0] c_ERRO      = {1'b1, {PW{1'b0}}};
    localparam logic [PW:0] c_ACEITO_LO = {1'b1, PW'(1)};
    localparam logic [PW:0] c_ACEITO_HI = {1'b1, PW'(2)};

    localparam logic [PW:0] c_N_POS      = (PW+1)'(N_POS);
    localparam logic [PW:0] c_SPLIT      = (PW+1)'(SPLIT);
    localparam logic [7:0]  c_MAX_PASSOS = 8'(MAX_PASSOS);

    if (N_POS < 2 || N_POS > (1 << PW) - 1 || SPLIT < 1 || SPLIT > N_POS - 1 ||
        MAX_PASSOS < 1 || MAX_PASSOS > 255 || TIMEOUT < 1 || TIMEOUT > 65535)
    begin : g_param_check
        $error("decodificador_cadeia: parameter out of range");
    end

    logic [PW:0] r_saida;
    logic [7:0]  r_passos;
    logic        r_evento;

    logic [1:0]  w_op;
    logic [PW:0] w_pos;
    logic [PW:0] w_cur;
    logic        w_idle;
    logic        w_in_pos;
    logic        w_pos_valid;
    logic        w_adj;
    logic [PW:0] w_nxt_saida;
    logic [7:0]  w_nxt_passos;

    assign w_op        = bus.Entrada[PW+1:PW];
    assign w_pos       = {1'b0, bus.Entrada[PW-1:0]};
    assign w_cur       = {1'b0, r_saida[PW-1:0]};
    assign w_idle      = (r_saida == c_IDLE);
    assign w_in_pos    = !r_saida[PW] && !w_idle;
    assign w_pos_valid = (w_pos != '0) && (w_pos <= c_N_POS);
    // One extra bit keeps p+1 from wrapping at the top of the position field.
    assign w_adj       = (w_pos == w_cur + 1'b1) || (w_pos + 1'b1 == w_cur);

`ifdef DECOD_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);
    logic [15:0] r_tmo;
    logic        w_tmo_hit;

    assign w_tmo_hit = !bus.Controle && w_in_pos && (r_tmo == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_tmo <= '0;
        end else if (bus.Controle || !w_in_pos || w_tmo_hit) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 16'd1;
        end
    end
`else
    logic w_tmo_hit;
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_nxt_saida  = r_saida;
        w_nxt_passos = r_passos;
        if (bus.Controle) begin
            if (w_idle) begin
                if (w_op == c_OP_MOVE && w_pos_valid) begin
                    w_nxt_saida  = w_pos;
                    w_nxt_passos = 8'd1;
                end
            end else if (w_in_pos) begin
                case (w_op)
                    c_OP_MOVE: begin
                        if (w_pos_valid && w_pos != w_cur) begin
                            if (!w_adj) begin
                                w_nxt_saida = c_ERRO;
                            end else if (r_passos >= c_MAX_PASSOS) begin
                                w_nxt_saida = c_ERRO;
                            end else begin
                                w_nxt_saida  = w_pos;
                                w_nxt_passos = r_passos + 8'd1;
                            end
                        end
                    end
                    c_OP_ACC_LO: begin
                        if (w_cur <= c_SPLIT) begin
                            w_nxt_saida = c_ACEITO_LO;
                        end
                    end
                    c_OP_ACC_HI: begin
                        if (w_cur > c_SPLIT) begin
                            w_nxt_saida = c_ACEITO_HI;
                        end
                    end
                    c_OP_ABORT: begin
                        w_nxt_saida = c_ERRO;
                    end
                    default: begin
                        w_nxt_saida = r_saida;
                    end
                endcase
            end
        end else if (w_tmo_hit) begin
            w_nxt_saida = c_ERRO;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_saida  <= c_IDLE;
            r_passos <= '0;
            r_evento <= 1'b0;
        end else begin
            r_saida  <= w_nxt_saida;
            r_passos <= w_nxt_passos;
            // Pulse only on the entry into a terminal state, never while held.
            r_evento <= w_nxt_saida[PW] && !r_saida[PW];
        end
    end

    assign bus.Saida  = r_saida;
    assign bus.Passos = r_passos;
    assign bus.Fim    = r_saida[PW];
    assign bus.Evento = r_evento;

endmodule
`default_nettype wire

// File: tb/tb_decodificador_cadeia.sv
`default_nettype none
// =============================================================================
// Module      : tb_decodificador_cadeia
// Description : Directed self-checking bench; dut_a uses default parameters,
//               dut_b uses MAX_PASSOS=4 and TIMEOUT=10 on shared stimulus.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_decodificador_cadeia;

    localparam logic [1:0] c_MOVE   = 2'b00;
    localparam logic [1:0] c_ACC_LO = 2'b01;
    localparam logic [1:0] c_ACC_HI = 2'b10;
    localparam logic [1:0] c_ABORT  = 2'b11;

    logic       clk;
    logic       rst;
    logic       r_ctl;
    logic [4:0] r_ent;
    int         n_chk;
    int         n_err;

    decodificador_cadeia_if #(.PW(3)) bus_a ();
    decodificador_cadeia_if #(.PW(3)) bus_b ();

    assign bus_a.Controle = r_ctl;
    assign bus_a.Entrada  = r_ent;
    assign bus_b.Controle = r_ctl;
    assign bus_b.Entrada  = r_ent;

    decodificador_cadeia dut_a (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus_a.slave)
    );

    decodificador_cadeia #(
        .MAX_PASSOS (4),
        .TIMEOUT    (10)
    ) dut_b (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tok(input logic [1:0] op, input logic [2:0] pos);
        r_ctl = 1'b1;
        r_ent = {op, pos};
        @(posedge clk);
        #1;
        r_ctl = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        r_ctl = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        r_ctl = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        r_ctl = 1'b0;
        r_ent = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_saida", int'(bus_a.Saida), 0);
        chk("rst_passos", int'(bus_a.Passos), 0);
        chk("rst_fim", int'(bus_a.Fim), 0);
        chk("rst_evento", int'(bus_a.Evento), 0);

        // Low-zone accept
        tok(c_MOVE, 3'd1);   chk("s1_m1", int'(bus_a.Saida), 1);
        chk("s1_p1", int'(bus_a.Passos), 1);
        tok(c_MOVE, 3'd2);   chk("s1_m2", int'(bus_a.Saida), 2);
        tok(c_MOVE, 3'd3);   chk("s1_m3", int'(bus_a.Saida), 3);
        chk("s1_fim0", int'(bus_a.Fim), 0);
        tok(c_ACC_LO, 3'd0); chk("s1_acc", int'(bus_a.Saida), 9);
        chk("s1_passos", int'(bus_a.Passos), 3);
        chk("s1_fim", int'(bus_a.Fim), 1);
        chk("s1_ev", int'(bus_a.Evento), 1);
        idle_cycles(1);      chk("s1_ev_off", int'(bus_a.Evento), 0);
        chk("s1_hold", int'(bus_a.Saida), 9);

        // High-zone accept, ACC_LO ignored above the split
        do_reset();
        tok(c_MOVE, 3'd5);   chk("s2_m5", int'(bus_a.Saida), 5);
        tok(c_MOVE, 3'd6);   chk("s2_m6_ign", int'(bus_a.Saida), 5);
        tok(c_MOVE, 3'd4);   chk("s2_m4", int'(bus_a.Saida), 4);
        tok(c_ACC_LO, 3'd0); chk("s2_acclo_ign", int'(bus_a.Saida), 4);
        tok(c_ACC_HI, 3'd0); chk("s2_acchi", int'(bus_a.Saida), 10);
        chk("s2_ev", int'(bus_a.Evento), 1);
        chk("s2_passos", int'(bus_a.Passos), 2);

        // Non-adjacent jump, absorbing error, reset out of terminal
        do_reset();
        tok(c_MOVE, 3'd2);   chk("s3_m2", int'(bus_a.Saida), 2);
        tok(c_MOVE, 3'd4);   chk("s3_jump", int'(bus_a.Saida), 8);
        chk("s3_ev", int'(bus_a.Evento), 1);
        tok(c_MOVE, 3'd3);   chk("s3_abs", int'(bus_a.Saida), 8);
        chk("s3_ev_once", int'(bus_a.Evento), 0);
        tok(c_ABORT, 3'd0);  chk("s3_abs2", int'(bus_a.Saida), 8);
        chk("s3_ev_once2", int'(bus_a.Evento), 0);
        do_reset();
        chk("s3_rst_saida", int'(bus_a.Saida), 0);
        chk("s3_rst_passos", int'(bus_a.Passos), 0);

        // Ignored tokens in idle and at a position
        tok(c_ABORT, 3'd0);  chk("s4_idle_abort", int'(bus_a.Saida), 0);
        tok(c_ACC_LO, 3'd1); chk("s4_idle_acc", int'(bus_a.Saida), 0);
        tok(c_MOVE, 3'd3);   chk("s4_m3", int'(bus_a.Saida), 3);
        tok(c_MOVE, 3'd3);   chk("s4_self", int'(bus_a.Saida), 3);
        tok(c_MOVE, 3'd0);   chk("s4_zero", int'(bus_a.Saida), 3);
        tok(c_MOVE, 3'd7);   chk("s4_oor", int'(bus_a.Saida), 3);
        chk("s4_passos", int'(bus_a.Passos), 1);
        tok(c_ABORT, 3'd0);  chk("s4_abort", int'(bus_a.Saida), 8);

        // Budget of 4 on dut_b; dut_a (budget 15) keeps walking
        do_reset();
        tok(c_MOVE, 3'd1);
        tok(c_MOVE, 3'd2);
        tok(c_MOVE, 3'd1);
        tok(c_MOVE, 3'd2);   chk("s5_b_p4", int'(bus_b.Passos), 4);
        tok(c_MOVE, 3'd3);   chk("s5_b_erro", int'(bus_b.Saida), 8);
        chk("s5_b_hold", int'(bus_b.Passos), 4);
        chk("s5_b_ev", int'(bus_b.Evento), 1);
        chk("s5_a_s", int'(bus_a.Saida), 3);
        chk("s5_a_p", int'(bus_a.Passos), 5);

        // Default budget of 15 on dut_a
        do_reset();
        for (int i = 0; i < 15; i++) tok(c_MOVE, (i % 2 == 0) ? 3'd1 : 3'd2);
        chk("s6_a_s", int'(bus_a.Saida), 1);
        chk("s6_a_p15", int'(bus_a.Passos), 15);
        tok(c_MOVE, 3'd2);   chk("s6_a_erro", int'(bus_a.Saida), 8);
        chk("s6_a_hold", int'(bus_a.Passos), 15);

        // Inactivity on dut_b (TIMEOUT=10), count restarted by a token at cycle 9
        do_reset();
        tok(c_MOVE, 3'd2);   chk("s7_m2", int'(bus_b.Saida), 2);
        idle_cycles(8);
        tok(c_MOVE, 3'd2);   chk("s7_pulse", int'(bus_b.Saida), 2);
        idle_cycles(10);     chk("s7_at_limit", int'(bus_b.Saida), 2);
        idle_cycles(1);
`ifdef DECOD_TIMEOUT_EN
        chk("s7_timeout", int'(bus_b.Saida), 8);
        chk("s7_ev", int'(bus_b.Evento), 1);
`else
        chk("s7_hold", int'(bus_b.Saida), 2);
        chk("s7_no_ev", int'(bus_b.Evento), 0);
`endif
        chk("s7_a_hold", int'(bus_a.Saida), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decodificador_cadeia.md
# decodificador_cadeia

Parametrised path decoder: a token-driven walker over a linear chain of `N_POS` positions, ending in an error or one of two accept zones. Generalises the fixed 5-position, 7-bit-code decoder to configurable chain length, position field width and accept split. Adds a step budget, a one-cycle terminal event pulse and an optional inactivity timeout. Sits between the symbol front end (`Entrada`/`Controle`) and the result display/handshake logic.

## Interface
Parameters:
- `PW`, 3: position field width; `Entrada` is `PW+2` bits and `Saida` is `PW+1` bits.
- `N_POS`, 5: number of chain positions, 2..2^PW-1.
- `SPLIT`, 3: last position of the low accept zone, 1..N_POS-1.
- `MAX_PASSOS`, 15: move budget, 1..255.
- `TIMEOUT`, 255: inactivity limit in cycles, 1..65535; used only with `DECOD_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Controle`  in  1  token-valid qualifier; `Entrada` is sampled only when high.
- `Entrada`  in  PW+2  token `{op[1:0], pos[PW-1:0]}`; op encoding: 00 MOVE, 01 ACC_LO, 10 ACC_HI, 11 ABORT.
- `Saida`  out  PW+1  state code: 0 idle; 1..N_POS position; `{1,0…0}` ERRO; `{1,0…01}` ACEITO_LO; `{1,0…010}` ACEITO_HI. With defaults these are 8/9/10.
- `Passos`  out  8  number of accepted moves, including the first move from idle.
- `Fim`  out  1  high while `Saida` is terminal; equals `Saida[PW]`.
- `Evento`  out  1  one-cycle pulse in the cycle after a terminal state is entered.

## Operation
All transitions below occur on a clk edge with `Controle`=1. `Reset` overrides everything.

Idle (0):
- MOVE with pos in 1..N_POS goes to pos and sets `Passos`=1.
- Every other token is ignored.

Position p:
- MOVE to p-1 or p+1 (within 1..N_POS) is a valid step. It goes to the target and increments `Passos`.
- If that step would take `Passos` above MAX_PASSOS, the result is ERRO and `Passos` is held.
- MOVE to p itself, pos=0, or pos>N_POS is ignored.
- MOVE to any other in-range position (non-adjacent) goes to ERRO.
- ACC_LO goes to ACEITO_LO if p≤SPLIT; otherwise it is ignored.
- ACC_HI goes to ACEITO_HI if p>SPLIT; otherwise it is ignored.
- ABORT goes to ERRO.

Terminal states (ERRO, ACEITO_LO, ACEITO_HI):
- Absorbing; all tokens are ignored.
- Exit only via `Reset`.

`Controle`=0: state is held, apart from the timeout rule in Configuration.

## Timing
- Reset values: `Saida`=0, `Passos`=0, `Fim`=0, `Evento`=0, timeout counter 0. Reset takes effect at the next clk edge and applies mid-walk and in terminal states alike.
- Latency: one cycle. A token sampled at edge k appears on `Saida`/`Passos` after edge k.
- `Fim` follows `Saida` with no added latency.
- `Evento` is registered: high for exactly one cycle following the edge on which `Saida` became terminal. It never repeats while the state is held.
- Back-to-back tokens, one per cycle, are accepted with no bubbles.
- Boundaries:
  - Position 1 has no p-1 neighbour; position N_POS has no p+1 neighbour.
  - `Passos` never wraps.

## Configuration
- `DECOD_TIMEOUT_EN` defined: a 16-bit inactivity counter is active.
  - It runs only while in a position state with `Controle`=0.
  - It clears on `Controle`=1, in idle, in terminal states, and on `Reset`.
  - When it reaches TIMEOUT, the next edge moves to ERRO and pulses `Evento`.
  - If `Controle`=1 on that same cycle, the token is processed and the counter clears.
- Undefined: no counter is built; positions hold indefinitely.

## Test plan
All scenarios use default parameters.
- Reset then MOVE 1, MOVE 2, MOVE 3, ACC_LO -> `Saida` 1,2,3,9; `Passos`=3; `Evento` high for one cycle; `Fim`=1.
- MOVE 5, MOVE 4, ACC_LO, ACC_HI -> ACC_LO ignored (`Saida` stays 4); then `Saida`=10.
- MOVE 2, MOVE 4 -> `Saida`=8. Further tokens leave `Saida`=8 with no second `Evento`. `Reset` -> `Saida`=0, `Passos`=0.
- ABORT in idle is ignored. MOVE 3, MOVE 3, MOVE 0, MOVE 7 leave `Saida`=3; then ABORT -> 8.
- MAX_PASSOS=4: MOVE 1,2,1,2, then MOVE 3 -> `Saida`=8, `Passos`=4.
- With `DECOD_TIMEOUT_EN` and TIMEOUT=10:
  - MOVE 2 then `Controle`=0 -> `Saida`=8 after the limit is reached, `Evento` pulses.
  - A `Controle` pulse at cycle 9 restarts the count.
